pixel_stream_receiver: RTL

- Input end of the CORE pixel interface: accepts the 16-bit in_valid/in_data word stream driven into the SIFT core.
- Unpacks each word into two 8-bit grayscale pixels, buffers them in a small word FIFO, and emits one pixel per cycle with raster coordinates and frame markers.
- Downstream consumers are the Gaussian blur line buffers.
- in_data has no ready signal, so the block absorbs rate mismatch and flags overflow.

---
 rtl/pixel_stream_receiver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_receiver.sv
// Pixel stream receiver: unpacks 16-bit words into 8-bit raster pixels with coordinates and frame flags.
// Optional per-frame pixel checksum output enabled by defining PIXEL_CHECKSUM_EN.
module pixel_stream_receiver #(
  parameter int COLS       = 640,
  parameter int ROWS       = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        overflow,
  output logic [3:0]  fifo_level
`ifdef PIXEL_CHECKSUM_EN
  ,
  output logic [23:0] frame_sum,
  output logic        frame_sum_valid
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [9:0]    X_LAST   = 10'(COLS - 1);
  localparam logic [8:0]    Y_LAST   = 9'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, HI, LO} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic            full, hs, push, pop;
  logic [15:0]     head;

  // Pop only on the low-byte handshake; a coinciding pop frees the slot for a push on a full FIFO.
  always_comb begin
    full = (count_q == CNT_FULL);
    hs   = pix_valid & pix_ready;
    pop  = hs & (state_q == LO);
    push = in_valid & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    ovf_d = ovf_q | (in_valid & full & ~pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != '0) state_d = HI;
      HI:   if (hs) state_d = LO;
      LO:   if (hs) state_d = (count_d != '0) ? HI : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hs) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    pix_valid  = (state_q != IDLE);
    pix_data   = '0;
    if (state_q == HI)      pix_data = head[15:8];
    else if (state_q == LO) pix_data = head[7:0];
    pix_x      = x_q;
    pix_y      = y_q;
    pix_sof    = pix_valid & (x_q == '0) & (y_q == '0);
    pix_eol    = pix_valid & (x_q == X_LAST);
    pix_eof    = pix_valid & (x_q == X_LAST) & (y_q == Y_LAST);
    overflow   = ovf_q;
    fifo_level = 4'(count_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  logic [23:0] sum_q, sum_d, fsum_q, fsum_d, total;
  logic        fsv_q, fsv_d;

  // The eof pixel is folded into the reported total; the accumulator restarts for the next frame.
  always_comb begin
    total  = sum_q + {16'd0, pix_data};
    sum_d  = sum_q;
    fsum_d = fsum_q;
    fsv_d  = 1'b0;
    if (hs) begin
      if (pix_eof) begin
        fsum_d = total;
        fsv_d  = 1'b1;
        sum_d  = '0;
      end else begin
        sum_d  = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      fsum_q <= '0;
      fsv_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      fsum_q <= fsum_d;
      fsv_q  <= fsv_d;
    end
  end

  assign frame_sum       = fsum_q;
  assign frame_sum_valid = fsv_q;
`endif

endmodule
